if_fetch_slice: RTL and testbench
=================================

// Module: if_fetch_slice
// PURPOSE
//  Instruction-fetch stage; feeds the decode stage's PC_inc_in/instr_in every cycle.
//  Holds the PC and runs a req/rdy handshake with instruction memory.
//  Presents a NOP bubble while a fetch is pending, and holds the current instruction under stall.
//  Applies taken branch/call/ret redirects, including safe discard of an in-flight fetch.
// PARAMETERS
//  RESET_PC    16'h0000  PC loaded on reset
//  NOP_INSTR   16'hF000  bubble instruction (opcode F = FLUSH, no control effects)
//  HALT_INSTR  16'hFFFF  halt encoding (used only with IF_HALT_DETECT_EN)
// PORTS
//  clk          in   1   clock, all state updates on posedge
//  rst          in   1   synchronous, active-high reset
//  stall        in   1   decode cannot accept a new instruction this cycle
//  redirect     in   1   taken branch/call/ret; discard sequential stream
//  redirect_pc  in   16  new fetch address, valid with redirect
//  imem_req     out  1   fetch request
//  imem_addr    out  16  fetch address; stable while imem_req high
//  imem_rdy     in   1   one-cycle response strobe, only while imem_req high
//  imem_data    in   16  instruction word, valid with imem_rdy
//  PC_inc       out  16  address of presented instr + 1 (to decode PC_inc_in)
//  instr        out  16  presented instruction (to decode instr_in)
//  halted       out  1   fetch stopped (IF_HALT_DETECT_EN only, else tied 0)
// BEHAVIOUR
//  - Reset: pc=RESET_PC, state=REQ, hold reg=NOP_INSTR, instr=NOP_INSTR, PC_inc=0, halted=0.
//    imem_req=0 while rst is high; imem_req=1 in the first cycle after release.
//  - State REQ:
//    - imem_req=1, imem_addr=pc.
//    - No imem_rdy: instr=NOP_INSTR.
//    - imem_rdy & !stall: instr=imem_data (combinational), PC_inc=pc+1; pc<=pc+1; stay in REQ.
//      Back-to-back fetch gives 1 instruction/cycle with a 1-cycle memory.
//    - imem_rdy & stall: hold<=imem_data, hold_pc<=pc; go to HOLD; instr=NOP_INSTR this cycle.
//  - State HOLD:
//    - imem_req=0; instr=hold, PC_inc=hold_pc+1 every cycle. Decode re-latches the same word.
//    - !stall: pc<=hold_pc+1; go to REQ.
//  - State DROP (redirect while a request is in flight):
//    - imem_req=1; imem_addr keeps the old pc; instr=NOP_INSTR.
//    - On imem_rdy: discard data; pc<=saved target; go to REQ.
//  - Redirect (priority over stall and rdy):
//    - In REQ with imem_rdy: discard data; pc<=redirect_pc; stay in REQ.
//    - In REQ without rdy: tgt<=redirect_pc; go to DROP.
//    - In HOLD: discard hold; pc<=redirect_pc; go to REQ.
//    - In DROP: tgt<=redirect_pc (last redirect wins).
//    - instr=NOP_INSTR in any cycle where redirect=1.
//  - Arithmetic: all PC math is 16-bit modulo; 16'hFFFF+1 wraps to 16'h0000.
//  - When instr=NOP_INSTR as a bubble, PC_inc=pc+1. Decode ignores PC_inc for FLUSH.
//  - Reset mid-fetch: an outstanding imem request is abandoned. Memory must tolerate
//    dropped requests across reset.
//  - imem_rdy without imem_req is illegal; an assertion flags it in simulation.
// CONFIGURATION
//  - IF_HALT_DETECT_EN defined:
//    - A fetched word equal to HALT_INSTR is presented once, then state=HALT.
//    - In HALT: imem_req=0, instr=NOP_INSTR, halted=1; only rst exits.
//    - A redirect in the same cycle as the halt word cancels the halt.
//  - IF_HALT_DETECT_EN undefined: HALT_INSTR is an ordinary word; no HALT state; halted=0.
// TESTING
//  - Reset then 1-cycle memory, no stall:
//    addr 0,1,2 fetched on consecutive cycles; instr=mem[n], PC_inc=n+1.
//  - 3-cycle latency memory:
//    2 NOP_INSTR cycles, then the word; imem_addr stable for all 3 cycles.
//  - stall=1 for 4 cycles when word at 0x0010 returns:
//    instr=that word and PC_inc=0x0011 held for 4 cycles; next req addr=0x0011.
//  - Redirect to 0x0200 while fetch of 0x0005 is pending, rdy 2 cycles later:
//    data discarded; next req addr=0x0200; no word from 0x0005 presented.
//  - Redirect and imem_rdy in the same cycle:
//    instr=NOP_INSTR; next imem_addr=redirect_pc.
//  - pc=16'hFFFF fetch:
//    PC_inc=16'h0000; next req addr=0.
//  - With IF_HALT_DETECT_EN, mem[3]=16'hFFFF:
//    halted=1 from the next cycle; imem_req stays 0 until rst.

Source files
------------

// File: rtl/if_fetch_slice.sv
`default_nettype none
// if_fetch_slice: instruction-fetch stage with imem req/rdy handshake, stall hold and redirect discard.
// Optional IF_HALT_DETECT_EN: stop fetching after presenting HALT_INSTR. Rev 1.0
module if_fetch_slice #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [15:0] NOP_INSTR  = 16'hF000,
  parameter logic [15:0] HALT_INSTR = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [15:0] imem_data,
  output logic [15:0] PC_inc,
  output logic [15:0] instr,
  output logic        halted
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_HOLD = 2'd1,
    S_DROP = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t      r_state;
  logic [15:0] r_pc;
  logic [15:0] r_hold;
  logic [15:0] r_hold_pc;
  logic [15:0] r_tgt;
  logic [15:0] w_pc_inc;
  logic [15:0] w_hold_pc_inc;
  logic        w_halt_en;

`ifdef IF_HALT_DETECT_EN
  assign w_halt_en = 1'b1;
  assign halted    = (r_state == S_HALT);
`else
  assign w_halt_en = 1'b0;
  assign halted    = 1'b0;
`endif

  assign w_pc_inc      = r_pc + 16'd1;
  assign w_hold_pc_inc = r_hold_pc + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_REQ;
      r_pc      <= RESET_PC;
      r_hold    <= NOP_INSTR;
      r_hold_pc <= RESET_PC;
      r_tgt     <= RESET_PC;
    end else begin
      case (r_state)
        S_REQ: begin
          if (redirect) begin
            // Without a response the request stays outstanding and must be drained.
            if (imem_rdy) begin
              r_pc <= redirect_pc;
            end else begin
              r_tgt   <= redirect_pc;
              r_state <= S_DROP;
            end
          end else if (imem_rdy) begin
            if (stall) begin
              r_hold    <= imem_data;
              r_hold_pc <= r_pc;
              r_state   <= S_HOLD;
            end else begin
              r_pc <= w_pc_inc;
              if (w_halt_en && (imem_data == HALT_INSTR))
                r_state <= S_HALT;
            end
          end
        end
        S_HOLD: begin
          if (redirect) begin
            r_pc    <= redirect_pc;
            r_state <= S_REQ;
          end else if (!stall) begin
            r_pc    <= w_hold_pc_inc;
            r_state <= (w_halt_en && (r_hold == HALT_INSTR)) ? S_HALT : S_REQ;
          end
        end
        S_DROP: begin
          if (redirect)
            r_tgt <= redirect_pc;
          if (imem_rdy) begin
            r_pc    <= redirect ? redirect_pc : r_tgt;
            r_state <= S_REQ;
          end
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state <= S_REQ;
        end
      endcase
    end
  end

  always_comb begin
    imem_req  = 1'b0;
    imem_addr = r_pc;
    instr     = NOP_INSTR;
    PC_inc    = w_pc_inc;
    if (rst) begin
      PC_inc = 16'h0000;
    end else begin
      case (r_state)
        S_REQ: begin
          imem_req = 1'b1;
          if (imem_rdy && !stall && !redirect)
            instr = imem_data;
        end
        S_HOLD: begin
          if (!redirect) begin
            instr  = r_hold;
            PC_inc = w_hold_pc_inc;
          end
        end
        S_DROP: begin
          imem_req = 1'b1;
        end
        default: begin
          imem_req = 1'b0;
        end
      endcase
    end
  end

  // A response strobe is only meaningful against an outstanding request.
  a_rdy_needs_req: assert property (@(posedge clk) disable iff (rst) imem_rdy |-> imem_req);

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_slice.sv
`default_nettype none
// tb_if_fetch_slice: table-driven vectors plus directed multi-cycle sequences for if_fetch_slice.
module tb_if_fetch_slice;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rdy;
  logic [15:0] imem_data;
  logic [15:0] PC_inc;
  logic [15:0] instr;
  logic        halted;

  int n_cmp  = 0;
  int n_fail = 0;

  // Memory model: response after lat cycles of continuous request.
  int   lat      = 1;
  int   cnt      = 0;
  logic halt_mem = 1'b0;

  always #5 clk = ~clk;

  if_fetch_slice dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdy    (imem_rdy),
    .imem_data   (imem_data),
    .PC_inc      (PC_inc),
    .instr       (instr),
    .halted      (halted)
  );

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (halt_mem && a == 16'h0003) return 16'hFFFF;
    return 16'h1000 | (a & 16'h0FFF);
  endfunction

  always @(posedge clk) begin
    if (rst || !imem_req || imem_rdy) cnt <= 0;
    else cnt <= cnt + 1;
  end

  assign imem_rdy  = imem_req && (cnt == lat - 1);
  assign imem_data = imem_rdy ? mem_word(imem_addr) : 16'h0BAD;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset(input int l, input logic hm);
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
    lat = l; halt_mem = hm;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", {15'd0, imem_req}, 16'h0);
    chk("rst_instr", instr, 16'hF000);
    chk("rst_pcinc", PC_inc, 16'h0000);
    chk("rst_halted", {15'd0, halted}, 16'h0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Apply inputs for one cycle, check at negedge, return at posedge+1.
  task automatic cyc(input string tag, input logic s, input logic r, input logic [15:0] rp,
                     input logic e_req, input logic [15:0] e_addr,
                     input logic [15:0] e_ins, input logic [15:0] e_pci);
    stall = s; redirect = r; redirect_pc = rp;
    @(negedge clk);
    chk({tag, "_req"}, {15'd0, imem_req}, {15'd0, e_req});
    if (e_req) chk({tag, "_addr"}, imem_addr, e_addr);
    chk({tag, "_instr"}, instr, e_ins);
    chk({tag, "_pcinc"}, PC_inc, e_pci);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        s;
    logic        r;
    logic [15:0] rp;
    logic        req;
    logic [15:0] addr;
    logic [15:0] ins;
    logic [15:0] pci;
  } vec_t;

  vec_t tbl[14];
  logic [15:0] seen;

  initial begin
    // 1-cycle memory: streaming, stall/hold, redirect with rdy, redirect from HOLD, PC wrap.
    tbl[0]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h1000, 16'h0001};
    tbl[1]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0001, 16'h1001, 16'h0002};
    tbl[2]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0002, 16'h1002, 16'h0003};
    tbl[3]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0003, 16'hF000, 16'h0004};
    tbl[4]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0003, 16'h1003, 16'h0004};
    tbl[5]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0003, 16'h1003, 16'h0004};
    tbl[6]  = '{1'b0, 1'b1, 16'h0200, 1'b1, 16'h0004, 16'hF000, 16'h0005};
    tbl[7]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0200, 16'h1200, 16'h0201};
    tbl[8]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0201, 16'hF000, 16'h0202};
    tbl[9]  = '{1'b1, 1'b1, 16'h0300, 1'b0, 16'h0201, 16'hF000, 16'h0202};
    tbl[10] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0300, 16'h1300, 16'h0301};
    tbl[11] = '{1'b0, 1'b1, 16'hFFFF, 1'b1, 16'h0301, 16'hF000, 16'h0302};
    tbl[12] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'hFFFF, 16'h1FFF, 16'h0000};
    tbl[13] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h1000, 16'h0001};

    do_reset(1, 1'b0);
    for (int i = 0; i < 14; i++)
      cyc($sformatf("tbl%0d", i), tbl[i].s, tbl[i].r, tbl[i].rp,
          tbl[i].req, tbl[i].addr, tbl[i].ins, tbl[i].pci);

    // 3-cycle latency: two bubbles with a stable address, then the word.
    do_reset(3, 1'b0);
    cyc("lat3_c0", 1'b0, 1'b0, 16'h0, 1'b1, 16'h0000, 16'hF000, 16'h0001);
    cyc("lat3_c1", 1'b0, 1'b0, 16'h0, 1'b1, 16'h0000, 16'hF000, 16'h0001);
    cyc("lat3_c2", 1'b0, 1'b0, 16'h0, 1'b1, 16'h0000, 16'h1000, 16'h0001);
    cyc("lat3_c3", 1'b0, 1'b0, 16'h0, 1'b1, 16'h0001, 16'hF000, 16'h0002);

    // Word at 0x0010 returns under a 4-cycle stall and is held until stall drops.
    do_reset(1, 1'b0);
    cyc("st_c0", 1'b0, 1'b1, 16'h0010, 1'b1, 16'h0000, 16'hF000, 16'h0001);
    cyc("st_c1", 1'b1, 1'b0, 16'h0, 1'b1, 16'h0010, 16'hF000, 16'h0011);
    cyc("st_c2", 1'b1, 1'b0, 16'h0, 1'b0, 16'h0010, 16'h1010, 16'h0011);
    cyc("st_c3", 1'b1, 1'b0, 16'h0, 1'b0, 16'h0010, 16'h1010, 16'h0011);
    cyc("st_c4", 1'b1, 1'b0, 16'h0, 1'b0, 16'h0010, 16'h1010, 16'h0011);
    cyc("st_c5", 1'b0, 1'b0, 16'h0, 1'b0, 16'h0010, 16'h1010, 16'h0011);
    cyc("st_c6", 1'b0, 1'b0, 16'h0, 1'b1, 16'h0011, 16'h1011, 16'h0012);

    // Redirects while requests are in flight: in-flight data is drained and discarded.
    do_reset(3, 1'b0);
    cyc("dr_c0", 1'b0, 1'b1, 16'h0005, 1'b1, 16'h0000, 16'hF000, 16'h0001);
    cyc("dr_c1", 1'b0, 1'b0, 16'h0, 1'b1, 16'h0000, 16'hF000, 16'h0001);
    cyc("dr_c2", 1'b0, 1'b0, 16'h0, 1'b1, 16'h0000, 16'hF000, 16'h0001);
    cyc("dr_c3", 1'b0, 1'b0, 16'h0, 1'b1, 16'h0005, 16'hF000, 16'h0006);
    cyc("dr_c4", 1'b0, 1'b1, 16'h0200, 1'b1, 16'h0005, 16'hF000, 16'h0006);
    seen = 16'h0;
    stall = 1'b0; redirect = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (!imem_rdy || instr == 16'h1005) begin
      n_fail++;
      $display("FAIL dr_drop: rdy=%b instr=%h, required rdy=1 and instr!=1005", imem_rdy, instr);
    end
    @(posedge clk); #1;
    cyc("dr_c6", 1'b0, 1'b0, 16'h0, 1'b1, 16'h0200, 16'hF000, 16'h0201);
    cyc("dr_c7", 1'b0, 1'b0, 16'h0, 1'b1, 16'h0200, 16'hF000, 16'h0201);
    cyc("dr_c8", 1'b0, 1'b0, 16'h0, 1'b1, 16'h0200, 16'h1200, 16'h0201);

    // Halt word at address 3.
    do_reset(1, 1'b1);
    cyc("h_c0", 1'b0, 1'b0, 16'h0, 1'b1, 16'h0000, 16'h1000, 16'h0001);
    cyc("h_c1", 1'b0, 1'b0, 16'h0, 1'b1, 16'h0001, 16'h1001, 16'h0002);
    cyc("h_c2", 1'b0, 1'b0, 16'h0, 1'b1, 16'h0002, 16'h1002, 16'h0003);
    cyc("h_c3", 1'b0, 1'b0, 16'h0, 1'b1, 16'h0003, 16'hFFFF, 16'h0004);
`ifdef IF_HALT_DETECT_EN
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("h_halted%0d", k), {15'd0, halted}, 16'h0001);
      chk($sformatf("h_req%0d", k), {15'd0, imem_req}, 16'h0);
      chk($sformatf("h_instr%0d", k), instr, 16'hF000);
      @(posedge clk); #1;
    end
`else
    @(negedge clk);
    chk("h_halted", {15'd0, halted}, 16'h0);
    @(posedge clk); #1;
    cyc("h_c5", 1'b0, 1'b0, 16'h0, 1'b1, 16'h0005, 16'h1005, 16'h0006);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
